// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter: two requesters share one 8-bit ripple adder.
// Each 16-bit add runs as a low-byte pass then a high-byte pass.
//
// Ports:
//   clk, rst              clock, async active-high reset
//   reqN_valid/ready      request handshake (N = 0, 1)
//   reqN_a, reqN_b        16-bit operands
//   reqN_cin              carry-in
//   reqN_sub              subtract select (ADDER_SUB_EN only)
//   rsp_valid/ready       response handshake
//   rsp_id, rsp_sum       owning requester, 16-bit result
//   rsp_cout              carry out of the high pass
//   busy                  operation in flight
//
// Optional feature macro: ADDER_SUB_EN (adds reqN_sub ports).

module full_adder_b (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int i = 0; i < 8; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

module shared_adder_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ADDER_SUB_EN
    input  logic        req0_sub,
    input  logic        req1_sub,
`endif
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req0_cin,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    input  logic        req1_cin,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_sum,
    output logic        rsp_cout,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, LO, HI, RESP} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d;
    logic        cin_q, cin_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [7:0]  lo_q, lo_d, hi_q, hi_d;
    logic        carry_q, carry_d;
    logic        cout_q, cout_d;
    logic        sub_q, sub_d;

    logic        idle, grant, accept, inv;
    logic [7:0]  add_a, add_b, add_s;
    logic        add_ci, add_co;

    assign idle = (state_q == IDLE);

    // Tie goes to the requester that did not win last time,
    // unless fixed priority pins it to req0.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_q;
        else
            grant = req1_valid;
    end

    assign req0_ready = idle & req0_valid & ~grant;
    assign req1_ready = idle & req1_valid & grant;
    assign accept     = req0_ready | req1_ready;

    // Subtraction: invert B on both passes, carry-in of 1 on the low pass.
    assign inv    = sub_q;
    assign add_a  = (state_q == HI) ? a_q[15:8] : a_q[7:0];
    assign add_b  = ((state_q == HI) ? b_q[15:8] : b_q[7:0]) ^ {8{inv}};
    assign add_ci = (state_q == HI) ? carry_q : (cin_q | inv);

    full_adder_b u_add (
        .a  (add_a),
        .b  (add_b),
        .ci (add_ci),
        .s  (add_s),
        .co (add_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        id_d    = id_q;
        last_d  = last_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sub_d   = sub_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LO;
                    a_d     = grant ? req1_a : req0_a;
                    b_d     = grant ? req1_b : req0_b;
                    cin_d   = grant ? req1_cin : req0_cin;
                    id_d    = grant;
                    last_d  = grant;
`ifdef ADDER_SUB_EN
                    sub_d   = grant ? req1_sub : req0_sub;
`else
                    sub_d   = 1'b0;
`endif
                end
            end
            LO: begin
                lo_d    = add_s;
                carry_d = add_co;
                state_d = HI;
            end
            HI: begin
                hi_d    = add_s;
                cout_d  = add_co;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            lo_q    <= '0;
            hi_q    <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            id_q    <= id_d;
            last_q  <= last_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sub_q   <= sub_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_sum   = {hi_q, lo_q};
    assign rsp_cout  = cout_q;
    assign busy      = ~idle;
endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Randomized bench for shared_adder_arbiter.
// Scoreboard queue of expected results, popped by a negedge monitor.

module tb_shared_adder_arbiter;
    localparam int FP = 0;

    typedef struct {
        logic        id;
        logic [15:0] sum;
        logic        cout;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [15:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_cin = 1'b0, req1_cin = 1'b0;
    logic        req0_sub = 1'b0, req1_sub = 1'b0;
    logic        rsp_ready = 1'b0;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_cout, busy;
    logic [15:0] rsp_sum;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    logic last = 1'b1;
    logic acc0, acc1;
    exp_t q[$];

    shared_adder_arbiter #(.FIXED_PRIO(FP)) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef ADDER_SUB_EN
        .req0_sub   (req0_sub),
        .req1_sub   (req1_sub),
`endif
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain 17-bit arithmetic.
    function automatic logic [16:0] model(logic [15:0] a, logic [15:0] b,
                                          logic cin, logic sub);
        if (sub)
            return {1'b0, a} + {1'b0, ~b} + 17'd1;
        return {1'b0, a} + {1'b0, b} + {16'd0, cin};
    endfunction

    always @(negedge clk) begin : mon
        logic [1:0]  er;
        logic        ev;
        logic        free;
        logic [16:0] r;
        cyc++;
        if (rst) begin
            chk("rst_valid", 32'(rsp_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
            chk("rst_sum", 32'(rsp_sum), 32'd0);
            chk("rst_cout", 32'(rsp_cout), 32'd0);
            chk("rst_id", 32'(rsp_id), 32'd0);
            q.delete();
            last = 1'b1;
        end else begin
            free = (q.size() == 0);
            er = 2'b00;
            if (free) begin
                if (req0_valid && req1_valid)
                    er = (FP != 0 || last) ? 2'b01 : 2'b10;
                else
                    er = {req1_valid, req0_valid};
            end
            chk("ready", 32'({req1_ready, req0_ready}), 32'(er));
            chk("busy", 32'(busy), 32'(!free));
            ev = !free && (cyc >= q[0].cyc + 3);
            chk("rsp_valid", 32'(rsp_valid), 32'(ev));
            if (rsp_valid && !free) begin
                chk("rsp_sum", 32'(rsp_sum), 32'(q[0].sum));
                chk("rsp_cout", 32'(rsp_cout), 32'(q[0].cout));
                chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
                if (rsp_ready)
                    void'(q.pop_front());
            end
            if (er[1]) begin
                r = model(req1_a, req1_b, req1_cin, req1_sub);
                q.push_back('{1'b1, r[15:0], r[16], cyc});
                last = 1'b1;
            end else if (er[0]) begin
                r = model(req0_a, req0_b, req0_cin, req0_sub);
                q.push_back('{1'b0, r[15:0], r[16], cyc});
                last = 1'b0;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        acc0 = req0_valid & req0_ready;
        acc1 = req1_valid & req1_ready;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rnd8();
        case ($urandom_range(0, 3))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'h80;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic new0(logic v);
        req0_valid = v;
        req0_a = {rnd8(), rnd8()};
        req0_b = {rnd8(), rnd8()};
        req0_cin = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
        req0_sub = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic new1(logic v);
        req1_valid = v;
        req1_a = {rnd8(), rnd8()};
        req1_b = {rnd8(), rnd8()};
        req1_cin = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
        req1_sub = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic wait_acc(string nm);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc0 || acc1) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL %s act=no_accept exp=accept", nm);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic drain(string nm);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() != 0; i++)
            tick();
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL %s act=pending%0d exp=pending0", nm, q.size());
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;

        req0_a = 16'h00FF; req0_b = 16'h0001; req0_cin = 1'b0;
        req0_sub = 1'b0; req0_valid = 1'b1;
        wait_acc("t1_accept");
        drain("t1_drain");

        req1_a = 16'hFFFF; req1_b = 16'h0000; req1_cin = 1'b1;
        req1_sub = 1'b0; req1_valid = 1'b1;
        wait_acc("t2_accept");
        drain("t2_drain");

        new0(1'b1);
        new1(1'b1);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (acc0) new0(1'b1);
            if (acc1) new1(1'b1);
        end
        drain("t3_drain");

        rsp_ready = 1'b0;
        req0_a = 16'h1200; req0_b = 16'h0034; req0_cin = 1'b0;
        req0_sub = 1'b0; req0_valid = 1'b1;
        wait_acc("t4_accept");
        for (int i = 0; i < 10 && !rsp_valid; i++)
            tick();
        new1(1'b1);
        repeat (5) tick();
        rsp_ready = 1'b1;
        wait_acc("t4_held_req");
        drain("t4_drain");

        new0(1'b1);
        wait_acc("t5_accept");
        tick();
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        new1(1'b1);
        wait_acc("t5_after_rst");
        drain("t5_drain");

`ifdef ADDER_SUB_EN
        req0_a = 16'h0003; req0_b = 16'h0005; req0_cin = 1'b0;
        req0_sub = 1'b1; req0_valid = 1'b1;
        wait_acc("t6_sub");
        drain("t6_drain");
`endif

        new0(1'($urandom_range(0, 1)));
        new1(1'($urandom_range(0, 1)));
        for (int i = 0; i < 800; i++) begin
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
            if (acc0 || !req0_valid) new0(1'($urandom_range(0, 1)));
            if (acc1 || !req1_valid) new1(1'($urandom_range(0, 1)));
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
